// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// BUS_ARBITER_LOCK_EN (optional) enables locked back-to-back grants.
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  typedef logic mid_t;

  localparam int unsigned AW_DEF   = 30;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned MAX_LOCK = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LOCK_CW  = 3;
endpackage

// File: rtl/bus_arb_rr.sv
// 2-way round-robin grant with LAST pointer; under BUS_ARBITER_LOCK_EN a
// locked master keeps priority for up to MAX_LOCK consecutive grants.
module bus_arb_rr
  import bus_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic arb_en_i,
`ifdef BUS_ARBITER_LOCK_EN
  input  logic lock0_i,
  input  logic lock1_i,
`endif
  output logic gnt_vld_o,
  output mid_t gnt_id_o
);

  mid_t last_q;
  mid_t rr_id;

  assign rr_id     = (req0_i && req1_i) ? ~last_q : req1_i;
  assign gnt_vld_o = arb_en_i && (req0_i || req1_i);

`ifdef BUS_ARBITER_LOCK_EN
  logic               lock_q;
  mid_t               owner_q;
  logic [LOCK_CW-1:0] cnt_q;
  logic               lock_hold;
  logic               win_lock;

  // Lock priority lapses once the owner drops REQ or the grant cap is hit.
  assign lock_hold = lock_q && (cnt_q < LOCK_CW'(MAX_LOCK)) &&
                     (owner_q ? req1_i : req0_i);
  assign gnt_id_o  = lock_hold ? owner_q : rr_id;
  assign win_lock  = gnt_id_o ? lock1_i : lock0_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else if (gnt_vld_o) begin
      if (!lock_hold) last_q <= gnt_id_o;
      if (win_lock) begin
        lock_q  <= 1'b1;
        owner_q <= gnt_id_o;
        cnt_q   <= lock_hold ? cnt_q + LOCK_CW'(1) : LOCK_CW'(1);
      end else begin
        lock_q <= 1'b0;
        cnt_q  <= '0;
      end
    end
  end
`else
  assign gnt_id_o = rr_id;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       last_q <= 1'b1;
    else if (gnt_vld_o) last_q <= gnt_id_o;
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: one fixed-latency transaction at a time, one-cycle ACK.
// Optional macro BUS_ARBITER_LOCK_EN adds m0_lock_i/m1_lock_i.
//   IDLE | no transaction, arbitrate and register winner's request
//   XFER | slave bus driven, latency counter running
//   DONE | one-cycle ACK + read data to the winner
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          m0_req_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_be_i,
  input  logic [DW-1:0] m0_wd_i,
  output logic [DW-1:0] m0_rd_o,
  output logic          m0_ack_o,
  input  logic          m1_req_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_be_i,
  input  logic [DW-1:0] m1_wd_i,
  output logic [DW-1:0] m1_rd_o,
  output logic          m1_ack_o,
`ifdef BUS_ARBITER_LOCK_EN
  input  logic          m0_lock_i,
  input  logic          m1_lock_i,
`endif
  output logic [AW-1:0] s_addr_o,
  output logic          s_we_o,
  output logic [3:0]    s_be_o,
  output logic [DW-1:0] s_wd_o,
  input  logic [DW-1:0] s_rd_i,
  output logic          busy_o,
  output logic          gnt_id_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    s_addr_q, s_addr_d;
  logic             s_we_q, s_we_d;
  logic [3:0]       s_be_q, s_be_d;
  logic [DW-1:0]    s_wd_q, s_wd_d;
  logic             txn_we_q, txn_we_d;
  mid_t             own_q, own_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0]    rd0_q, rd0_d, rd1_q, rd1_d;

  logic gnt_vld;
  mid_t gnt_id;

  bus_arb_rr u_rr (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .req0_i    (m0_req_i && !ack0_q),
    .req1_i    (m1_req_i && !ack1_q),
    .arb_en_i  (state_q == IDLE),
`ifdef BUS_ARBITER_LOCK_EN
    .lock0_i   (m0_lock_i),
    .lock1_i   (m1_lock_i),
`endif
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_addr_d = s_addr_q;
    s_we_d   = 1'b0;
    s_be_d   = s_be_q;
    s_wd_d   = s_wd_q;
    txn_we_d = txn_we_q;
    own_d    = own_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rd0_d    = '0;
    rd1_d    = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d  = XFER;
          cnt_d    = CNT_W'(LATENCY);
          own_d    = gnt_id;
          s_addr_d = gnt_id ? m1_addr_i : m0_addr_i;
          s_we_d   = gnt_id ? m1_we_i   : m0_we_i;
          txn_we_d = gnt_id ? m1_we_i   : m0_we_i;
          s_be_d   = gnt_id ? m1_be_i   : m0_be_i;
          s_wd_d   = gnt_id ? m1_wd_i   : m0_wd_i;
        end
      end
      XFER: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          s_addr_d = '0;
          s_be_d   = '0;
          s_wd_d   = '0;
          if (own_q) begin
            ack1_d = 1'b1;
            rd1_d  = txn_we_q ? '0 : s_rd_i;
          end else begin
            ack0_d = 1'b1;
            rd0_d  = txn_we_q ? '0 : s_rd_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_addr_q <= '0;
      s_we_q   <= 1'b0;
      s_be_q   <= '0;
      s_wd_q   <= '0;
      txn_we_q <= 1'b0;
      own_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_addr_q <= s_addr_d;
      s_we_q   <= s_we_d;
      s_be_q   <= s_be_d;
      s_wd_q   <= s_wd_d;
      txn_we_q <= txn_we_d;
      own_q    <= own_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  assign s_addr_o = s_addr_q;
  assign s_we_o   = s_we_q;
  assign s_be_o   = s_be_q;
  assign s_wd_o   = s_wd_q;
  assign m0_ack_o = ack0_q;
  assign m1_ack_o = ack1_q;
  assign m0_rd_o  = rd0_q;
  assign m1_rd_o  = rd1_q;
  assign busy_o   = (state_q != IDLE);
  assign gnt_id_o = own_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (LATENCY=2).
// Define BUS_ARBITER_LOCK_EN to also exercise locked grants.
module tb_bus_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk, rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [3:0]    m0_be, m1_be;
  logic [DW-1:0] m0_wd, m1_wd, m0_rd, m1_rd;
  logic          m0_ack, m1_ack;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [3:0]    s_be;
  logic [DW-1:0] s_wd, s_rd;
  logic          busy, gnt_id;
`ifdef BUS_ARBITER_LOCK_EN
  logic          m0_lock, m1_lock;
`endif

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.LATENCY(2), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wd_i(m0_wd), .m0_rd_o(m0_rd), .m0_ack_o(m0_ack),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wd_i(m1_wd), .m1_rd_o(m1_rd), .m1_ack_o(m1_ack),
`ifdef BUS_ARBITER_LOCK_EN
    .m0_lock_i(m0_lock), .m1_lock_i(m1_lock),
`endif
    .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wd_o(s_wd),
    .s_rd_i(s_rd), .busy_o(busy), .gnt_id_o(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = '0; m0_wd = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = '0; m1_wd = '0;
    s_rd = '0;
`ifdef BUS_ARBITER_LOCK_EN
    m0_lock = 0; m1_lock = 0;
`endif
    repeat (2) step();
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (gnt_id !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt_id); end
    checks++; if ({m0_ack, m1_ack, s_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {m0_ack, m1_ack, s_we}); end
    checks++; if (s_addr !== '0)   begin errors++; $display("FAIL reset_saddr got %h want 0", s_addr); end
    checks++; if (m0_rd !== '0)    begin errors++; $display("FAIL reset_rd got %h want 0", m0_rd); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_m0_read();
    m0_addr = 30'h3000_0004; m0_we = 0; m0_be = 4'hF; s_rd = 32'hDEADBEEF; m0_req = 1;
    step();
    checks++; if (busy !== 1'b1)            begin errors++; $display("FAIL rd_busy got %b want 1", busy); end
    checks++; if (s_addr !== 30'h3000_0004) begin errors++; $display("FAIL rd_saddr1 got %h want 30000004", s_addr); end
    checks++; if (s_we !== 1'b0)            begin errors++; $display("FAIL rd_swe got %b want 0", s_we); end
    checks++; if (m0_ack !== 1'b0)          begin errors++; $display("FAIL rd_early_ack got %b want 0", m0_ack); end
    step();
    checks++; if (s_addr !== 30'h3000_0004) begin errors++; $display("FAIL rd_saddr2 got %h want 30000004", s_addr); end
    checks++; if (m0_ack !== 1'b0)          begin errors++; $display("FAIL rd_early_ack2 got %b want 0", m0_ack); end
    step();
    checks++; if (m0_ack !== 1'b1)          begin errors++; $display("FAIL rd_ack got %b want 1", m0_ack); end
    checks++; if (m0_rd !== 32'hDEADBEEF)   begin errors++; $display("FAIL rd_data got %h want deadbeef", m0_rd); end
    checks++; if (m1_ack !== 1'b0)          begin errors++; $display("FAIL rd_m1_ack got %b want 0", m1_ack); end
    checks++; if (s_addr !== '0)            begin errors++; $display("FAIL rd_saddr_done got %h want 0", s_addr); end
    m0_req = 0;
    step();
    checks++; if ({busy, m0_ack} !== 2'b00) begin errors++; $display("FAIL rd_idle got %b want 00", {busy, m0_ack}); end
    checks++; if (m0_rd !== '0)             begin errors++; $display("FAIL rd_hold0 got %h want 0", m0_rd); end
  endtask

  task automatic test_m1_write();
    m1_addr = 30'h1; m1_we = 1; m1_wd = 32'h12345678; m1_be = 4'b0011; m1_req = 1;
    step();
    checks++; if (s_we !== 1'b1)          begin errors++; $display("FAIL wr_swe got %b want 1", s_we); end
    checks++; if (s_be !== 4'b0011)       begin errors++; $display("FAIL wr_sbe got %b want 0011", s_be); end
    checks++; if (s_wd !== 32'h12345678)  begin errors++; $display("FAIL wr_swd got %h want 12345678", s_wd); end
    checks++; if (s_addr !== 30'h1)       begin errors++; $display("FAIL wr_saddr got %h want 1", s_addr); end
    checks++; if (gnt_id !== 1'b1)        begin errors++; $display("FAIL wr_gnt got %b want 1", gnt_id); end
    step();
    checks++; if (s_we !== 1'b0)          begin errors++; $display("FAIL wr_swe_once got %b want 0", s_we); end
    checks++; if (s_wd !== 32'h12345678)  begin errors++; $display("FAIL wr_swd2 got %h want 12345678", s_wd); end
    step();
    checks++; if ({m1_ack, m0_ack} !== 2'b10) begin errors++; $display("FAIL wr_ack got %b want 10", {m1_ack, m0_ack}); end
    checks++; if (m1_rd !== '0)           begin errors++; $display("FAIL wr_rd got %h want 0", m1_rd); end
    m1_req = 0; m1_we = 0;
    step();
    checks++; if (m1_ack !== 1'b0)        begin errors++; $display("FAIL wr_ack_len got %b want 0", m1_ack); end
  endtask

  task automatic test_back_to_back();
    logic exp_id;
    int   n;
    exp_id = 1'b0; n = 0;
    m0_addr = 30'h10; m1_addr = 30'h20; m0_we = 0; m1_we = 0;
    s_rd = 32'hA5A5_0F0F; m0_req = 1; m1_req = 1;
    for (int c = 0; c < 80 && n < 8; c++) begin
      step();
      if (m0_ack || m1_ack) begin
        checks++;
        if ({m0_ack, m1_ack} !== {~exp_id, exp_id}) begin
          errors++; $display("FAIL rr_order#%0d got m0=%b m1=%b want id %b", n, m0_ack, m1_ack, exp_id);
        end
        checks++;
        if (gnt_id !== exp_id) begin errors++; $display("FAIL rr_gnt#%0d got %b want %b", n, gnt_id, exp_id); end
        checks++;
        if ((exp_id ? m1_rd : m0_rd) !== 32'hA5A5_0F0F) begin
          errors++; $display("FAIL rr_data#%0d got %h want a5a50f0f", n, exp_id ? m1_rd : m0_rd);
        end
        exp_id = ~exp_id;
        n++;
      end
    end
    m0_req = 0; m1_req = 0;
    checks++; if (n !== 8) begin errors++; $display("FAIL rr_count got %0d want 8", n); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle got %b want 0", busy); end
  endtask

  task automatic test_hold_req();
    int  acks, busy_after;
    bit  drop;
    acks = 0; busy_after = 0; drop = 0;
    m0_addr = 30'h44; m0_we = 0; m0_req = 1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (drop) begin m0_req = 0; drop = 0; end
      if (m0_ack) begin acks++; drop = 1; end
      else if (acks > 0 && busy) busy_after++;
    end
    m0_req = 0;
    checks++; if (acks !== 1)       begin errors++; $display("FAIL hold_acks got %0d want 1", acks); end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL hold_reissue got %0d want 0", busy_after); end
  endtask

  task automatic test_reset_mid_xfer();
    bit got;
    got = 0;
    m0_addr = 30'hAB0; m0_we = 1; m0_wd = 32'hCAFEF00D; m0_be = 4'hF; m0_req = 1;
    step();
    checks++; if ({busy, s_we} !== 2'b11) begin errors++; $display("FAIL mid_pre got %b want 11", {busy, s_we}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, s_we, gnt_id} !== 3'b000) begin errors++; $display("FAIL mid_async got %b want 000", {busy, s_we, gnt_id}); end
    checks++; if (s_addr !== '0 || s_wd !== '0 || s_be !== '0) begin
      errors++; $display("FAIL mid_sbus got addr=%h wd=%h be=%b want 0", s_addr, s_wd, s_be);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (m0_ack || m1_ack) got = 1;
    end
    checks++; if (got !== 1'b0) begin errors++; $display("FAIL mid_no_ack got %b want 0", got); end
    rst_n = 1'b1; m0_we = 0; m1_we = 0; m0_req = 1; m1_req = 1;
    step();
    checks++; if ({busy, gnt_id} !== 2'b10) begin errors++; $display("FAIL post_rst_gnt got %b want 10", {busy, gnt_id}); end
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      step();
      if (m0_ack || m1_ack) got = 1;
    end
    checks++; if ({got, m0_ack, m1_ack} !== 3'b110) begin
      errors++; $display("FAIL post_rst_ack got seen=%b m0=%b m1=%b want 110", got, m0_ack, m1_ack);
    end
    m0_req = 0; m1_req = 0;
    repeat (2) step();
  endtask

`ifdef BUS_ARBITER_LOCK_EN
  task automatic test_lock();
    logic ids [5];
    logic exp [5];
    int   n;
    bit   got;
    exp[0] = 0; exp[1] = 0; exp[2] = 0; exp[3] = 0; exp[4] = 1;
    got = 0;
    m1_req = 1; m1_we = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      if (m1_ack) got = 1;
    end
    m1_req = 0;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL lock_setup got %b want 1", got); end
    step();
    n = 0; m0_lock = 1; m0_req = 1; m1_req = 1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step();
      if (m0_ack || m1_ack) begin ids[n] = m1_ack; n++; end
    end
    m0_req = 0; m1_req = 0; m0_lock = 0;
    checks++; if (n !== 5) begin errors++; $display("FAIL lock_count got %0d want 5", n); end
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        checks++;
        if (ids[i] !== exp[i]) begin errors++; $display("FAIL lock_order#%0d got %b want %b", i, ids[i], exp[i]); end
      end
    end
    repeat (2) step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_back_to_back();
    test_hold_req();
    test_reset_mid_xfer();
`ifdef BUS_ARBITER_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
